tff_mod_counter: RTL
====================

# tff_mod_counter

Parametrised modulo-N up/down counter built from a bank of T flip-flop cells. It generalises the single T flip-flop to WIDTH bits and adds count direction, parallel load, enable, saturate-or-wrap mode and terminal-count/wrap flags. It sits in the lab sequential library as the standard counter for timers, dividers and sequence generators.

## Interface
- WIDTH, 4, counter width in bits (≥1)
- MODULUS, 2**WIDTH, count range 0..MODULUS-1; 2 ≤ MODULUS ≤ 2**WIDTH
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high; clears all state immediately
- En  in  1  count enable
- Up  in  1  direction: 1 = increment, 0 = decrement
- Load  in  1  synchronous parallel load
- D  in  WIDTH  load value
- Sat  in  1  mode: 1 = saturate at terminal value, 0 = wrap
- Q  out  WIDTH  current count
- TC  out  1  terminal count (combinational)
- Wrap  out  1  registered one-cycle pulse after a wrap

## Operation
- Reset high: Q=0, Wrap=0 asynchronously. TC follows its equation, so with Reset high and Q=0, TC = En & ~Up.
- Priority at each rising edge: Reset > Load > En > hold.
- Load=1: if D ≤ MODULUS-1, Q←D; otherwise Q←MODULUS-1 (clamp). Wrap←0. En and Up are ignored.
- En=1, Load=0, Up=1: Q<MODULUS-1 → Q+1. Q=MODULUS-1 → 0 with Wrap←1 when Sat=0; Q holds with Wrap←0 when Sat=1.
- En=1, Load=0, Up=0: Q>0 → Q-1. Q=0 → MODULUS-1 with Wrap←1 when Sat=0; Q holds with Wrap←0 when Sat=1.
- En=0, Load=0: Q holds, Wrap←0.
- TC = En & ((Up & Q==MODULUS-1) | (~Up & Q==0)). TC is independent of Sat and Load.
- Each bit is a T cell. The toggle vector is T = Q ^ Qnext, so a bit toggles exactly when it must change. There is no separate D-register path.
- Arithmetic is WIDTH bits wide. Comparisons against MODULUS-1 use a WIDTH-bit constant. MODULUS = 2**WIDTH gives natural binary wrap.

## Timing
- Q and Wrap update on the rising Clock edge. Latency is one cycle from the input change to Q.
- Wrap is high for exactly the one cycle following the wrapping edge. Back-to-back wraps (MODULUS=2 under continuous count) hold Wrap high on consecutive cycles.
- TC is combinational from Q, En and Up, so it is valid in the same cycle as the terminal value. TC & ~Sat predicts Wrap on the next edge.
- Asserting Reset mid-count clears Q and Wrap without waiting for a clock edge. On deassertion, counting resumes at the first edge where Reset is low.
- Load and En together: Load wins, with no count that cycle.
- Changing Up in the same cycle as an En edge takes effect on that edge.
- Changing Sat at the terminal value takes effect on that edge.

## Structure
- Sub-module `tff_cell` has ports T, Reset, Clock, Q: one async-reset T flip-flop. The block instantiates WIDTH of them via generate.
- The top level holds the next-state/toggle logic, load clamp, TC and the Wrap register.
- Shared include `tff_defs.vh` holds the default WIDTH and the direction constants CNT_UP=1 and CNT_DN=0, so other counters in the library use the same values.
- Target size is 120–250 lines of RTL including `tff_cell`.

## Test plan
All cases use WIDTH=4, MODULUS=10.
- Reset then count: Reset=1 for 20 ns, then En=1, Up=1, Sat=0 for 12 cycles → Q=0,1,…,9,0,1. TC=1 while Q=9. Wrap=1 for exactly one cycle with Q=0.
- Down wrap: Load D=2, then En=1, Up=0 for 4 cycles → Q=2,1,0,9,8. TC=1 at Q=0. Wrap pulses with Q=9.
- Saturate: Sat=1, Up=1, Load D=8, count 4 cycles → Q=8,9,9,9. TC stays 1 at 9. Wrap never asserts.
- Load priority and clamp: Load=1, En=1, D=13 → Q=9 next edge. Load=1, D=5 → Q=5. Neither load produces a Wrap pulse.
- Async reset mid-run: counting at Q=6, raise Reset between clock edges → Q=0 and Wrap=0 before the next edge. Hold Reset for 2 edges → Q stays 0.
- Hold: En=0 for 5 cycles at Q=4 → Q=4 throughout and TC=0.

Source files
------------

// File: rtl/tff_mod_counter_pkg.sv
// Shared constants for the T-flip-flop counter family: default width,
// direction encoding and the per-edge operation selected by the control inputs.
package tff_mod_counter_pkg;

    localparam int TFF_DEF_WIDTH = 4;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_COUNT = 2'd2
    } cnt_op_e;

endpackage

// File: rtl/tff_mod_counter_cell.sv
// Single T flip-flop with asynchronous active-high reset; toggles on i_t.
module tff_cell (
    input  logic i_t,
    input  logic i_rst,
    input  logic i_clk,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= 1'b0;
        end else if (i_t) begin
            r_q <= ~r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-MODULUS up/down counter built from a bank of T cells, with load clamp,
// saturate-or-wrap mode, combinational terminal count and a registered wrap pulse.
module tff_mod_counter
    import tff_mod_counter_pkg::*;
#(
    parameter int WIDTH   = TFF_DEF_WIDTH,
    parameter int MODULUS = 2**WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_sat,
    output logic [WIDTH-1:0] o_q,
    output logic             o_tc,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    cnt_op_e          w_op;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_t;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_at_end;
    logic             w_wrap_next;
    logic             r_wrap;

    assign w_at_max  = (w_q == MAX_VAL);
    assign w_at_zero = (w_q == '0);
    assign w_at_end  = (i_up == CNT_UP) ? w_at_max : w_at_zero;

    always_comb begin
        w_op = OP_HOLD;
        if (i_load) begin
            w_op = OP_LOAD;
        end else if (i_en) begin
            w_op = OP_COUNT;
        end
    end

    always_comb begin
        w_q_next    = w_q;
        w_wrap_next = 1'b0;
        case (w_op)
            OP_LOAD: begin
                w_q_next = (i_d > MAX_VAL) ? MAX_VAL : i_d;
            end
            OP_COUNT: begin
                if (w_at_end) begin
                    // Saturate simply leaves w_q_next at the current value.
                    if (!i_sat) begin
                        w_q_next    = (i_up == CNT_UP) ? '0 : MAX_VAL;
                        w_wrap_next = 1'b1;
                    end
                end else begin
                    w_q_next = (i_up == CNT_UP) ? (w_q + ONE) : (w_q - ONE);
                end
            end
            default: begin
                w_q_next = w_q;
            end
        endcase
    end

    // Each cell toggles exactly on the bits that differ from the next count.
    assign w_t = w_q ^ w_q_next;

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        tff_cell u_cell (
            .i_t   (w_t[g]),
            .i_rst (i_rst),
            .i_clk (i_clk),
            .o_q   (w_q[g])
        );
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_next;
        end
    end

    assign o_q    = w_q;
    assign o_tc   = i_en & w_at_end;
    assign o_wrap = r_wrap;

endmodule
